// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding, stall/flush
// generation, an MDU pending-register scoreboard and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [AW-1:0]    rs1_d_i,
    input  logic [AW-1:0]    rs2_d_i,
    input  logic [AW-1:0]    rd_d_i,
    input  logic             reg_wr_en_d_i,
    input  logic             mdu_op_d_i,
    input  logic [AW-1:0]    rs1_e_i,
    input  logic [AW-1:0]    rs2_e_i,
    input  logic [AW-1:0]    rd_e_i,
    input  logic             load_e_i,
    input  logic             mdu_start_e_i,
    input  logic [AW-1:0]    rd_m_i,
    input  logic [AW-1:0]    rd_w_i,
    input  logic             reg_wr_en_m_i,
    input  logic             reg_wr_en_w_i,
    input  logic             mem_req_m_i,
    input  logic             mem_ready_i,
    input  logic             mdu_busy_i,
    input  logic             mdu_done_i,
    input  logic [AW-1:0]    mdu_rd_i,
    input  logic             pc_src_e_i,
    input  logic             clr_cnt_i,
    output logic [1:0]       forward_a_e_o,
    output logic [1:0]       forward_b_e_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_w_o,
    output logic             sb_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int NREG = 2**AW;

    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic mem_stall;
    logic raw_e;
    logic pend_src;
    logic waw;
    logic mdu_struct;
    logic use_stall;
    logic use_hold;
    logic branch;

    always_comb begin
        forward_a_e_o = 2'b00;
        forward_b_e_o = 2'b00;
        if (reg_wr_en_m_i && rd_m_i != '0 && rd_m_i == rs1_e_i)
            forward_a_e_o = 2'b10;
        else if (reg_wr_en_w_i && rd_w_i != '0 && rd_w_i == rs1_e_i)
            forward_a_e_o = 2'b01;
        if (reg_wr_en_m_i && rd_m_i != '0 && rd_m_i == rs2_e_i)
            forward_b_e_o = 2'b10;
        else if (reg_wr_en_w_i && rd_w_i != '0 && rd_w_i == rs2_e_i)
            forward_b_e_o = 2'b01;
    end

    // Memory handshake: an access in M holds while mem_req_m_i && !mem_ready_i;
    // the cycle mem_ready_i is high completes the access and the pipeline advances.
    assign mem_stall = mem_req_m_i && !mem_ready_i;

    assign raw_e      = (load_e_i || mdu_start_e_i) && rd_e_i != '0 &&
                        (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);
    assign pend_src   = pending_q[rs1_d_i] || pending_q[rs2_d_i];
    assign waw        = reg_wr_en_d_i && pending_q[rd_d_i];
    assign mdu_struct = mdu_op_d_i && (mdu_busy_i || mdu_start_e_i);
    assign use_stall  = raw_e || pend_src || waw || mdu_struct;

    // A taken branch discards the D instruction, so its hazards are irrelevant.
    assign branch   = pc_src_e_i && !mem_stall;
    assign use_hold = use_stall && !mem_stall && !pc_src_e_i;

    assign stall_f_o = mem_stall || use_hold;
    assign stall_d_o = mem_stall || use_hold;
    assign stall_e_o = mem_stall;
    assign stall_m_o = mem_stall;
    assign flush_d_o = branch;
    assign flush_e_o = branch || use_hold;
    assign flush_w_o = mem_stall;

    // Set is applied after clear so a same-register set/clear leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (mdu_done_i)
            pending_d[mdu_rd_i] = 1'b0;
        if (mdu_start_e_i && !mem_stall && rd_e_i != '0)
            pending_d[rd_e_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (clr_cnt_i) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall_f_o && stall_cnt_q != '1)
                    stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (flush_d_o && flush_cnt_q != '1)
                    flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign sb_busy_o   = |pending_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
endmodule
